// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory handshake plus the F/D pipeline register.
// The fetch unit drives the master side. Memory and decode sit on the slave side.
interface fetch_unit_if;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_VALID;
  logic [31:0] IMEM_RDATA;
  logic [31:0] D_INSTR;
  logic [31:0] D_PC;
  logic [31:0] D_PC4;
  logic        D_VALID;

  modport master (
    output IMEM_REQ, IMEM_ADDR, D_INSTR, D_PC, D_PC4, D_VALID,
    input  IMEM_VALID, IMEM_RDATA
  );

  modport slave (
    input  IMEM_REQ, IMEM_ADDR, D_INSTR, D_PC, D_PC4, D_VALID,
    output IMEM_VALID, IMEM_RDATA
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, a single outstanding imem request and a
// one-entry hold buffer, and loads the F/D register under hazard-unit stall/flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] REDIRECT_PC,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t      state, state_n;
  logic [31:0] f_pc, f_pc_n;
  logic [31:0] buf_instr, buf_instr_n;
  logic        buf_valid, buf_valid_n;
  logic        fd_load, fd_bubble;
  logic [31:0] fd_instr_n;
  logic        req;
  logic [31:0] req_addr;
  logic        flush_eff;
  logic [31:0] pc_plus4;
  logic [31:0] d_instr, d_pc, d_pc4;
  logic        d_valid;

  assign flush_eff = FLUSH & ~STALL;
  assign pc_plus4  = f_pc + 32'd4;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      f_pc      <= RESET_PC;
      buf_instr <= NOP_INSTR;
      buf_valid <= 1'b0;
      d_instr   <= NOP_INSTR;
      d_pc      <= 32'd0;
      d_pc4     <= 32'd0;
      d_valid   <= 1'b0;
    end else begin
      state     <= state_n;
      f_pc      <= f_pc_n;
      buf_instr <= buf_instr_n;
      buf_valid <= buf_valid_n;
      if (fd_load) begin
        d_instr <= fd_instr_n;
        d_pc    <= f_pc;
        d_pc4   <= pc_plus4;
        d_valid <= 1'b1;
      end else if (fd_bubble) begin
        d_instr <= NOP_INSTR;
        d_valid <= 1'b0;
      end
    end
  end

  // A flush outranks every state action. A stall only freezes F/D and the PC, so new requests may still go out.
  always_comb begin
    state_n     = state;
    f_pc_n      = f_pc;
    buf_instr_n = buf_instr;
    buf_valid_n = buf_valid;
    fd_load     = 1'b0;
    fd_bubble   = 1'b0;
    fd_instr_n  = bus.IMEM_RDATA;
    req         = 1'b0;
    req_addr    = f_pc;
    if (flush_eff) begin
      f_pc_n      = {REDIRECT_PC[31:2], 2'b00};
      buf_valid_n = 1'b0;
      fd_bubble   = 1'b1;
      state_n     = (state == S_WAIT && !bus.IMEM_VALID) ? S_DROP : S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!buf_valid) begin
            req       = 1'b1;
            state_n   = S_WAIT;
            fd_bubble = ~STALL;
          end else if (!STALL) begin
            fd_load     = 1'b1;
            fd_instr_n  = buf_instr;
            f_pc_n      = pc_plus4;
            buf_valid_n = 1'b0;
            req         = 1'b1;
            req_addr    = pc_plus4;
            state_n     = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.IMEM_VALID) begin
            if (!STALL) begin
              fd_load  = 1'b1;
              f_pc_n   = pc_plus4;
              req      = 1'b1;
              req_addr = pc_plus4;
            end else begin
              buf_instr_n = bus.IMEM_RDATA;
              buf_valid_n = 1'b1;
              state_n     = S_IDLE;
            end
          end else begin
            fd_bubble = ~STALL;
          end
        end
        S_DROP: begin
          if (bus.IMEM_VALID) begin
            req     = 1'b1;
            state_n = S_WAIT;
          end
          fd_bubble = ~STALL;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign bus.IMEM_REQ  = req & RST_N;
  assign bus.IMEM_ADDR = {req_addr[31:2], 2'b00};
  assign bus.D_INSTR   = d_instr;
  assign bus.D_PC      = d_pc;
  assign bus.D_PC4     = d_pc4;
  assign bus.D_VALID   = d_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-configurable memory model feeds
// responses, and a scoreboard of expected program-order PCs is compared against every F/D load.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK;
  logic        RST_N;
  logic        STALL;
  logic        FLUSH;
  logic [31:0] REDIRECT_PC;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .STALL(STALL),
    .FLUSH(FLUSH),
    .REDIRECT_PC(REDIRECT_PC),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int pass_count = 0;
  int check_count = 0;

  logic [31:0] sb[$];
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  int          mem_waits = 0;
  logic [31:0] mem_addr = 32'd0;
  logic        inject_late = 1'b0;
  logic        last_req;
  logic [31:0] last_addr;
  int          valid_edges = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  // One clock cycle, entered and left at a falling edge: memory model drives the
  // response, the request is sampled, and each fresh F/D load is scored.
  task automatic applyStimulus(input logic stall, input logic flush, input logic [31:0] redir);
    logic gave_valid;
    STALL       = stall;
    FLUSH       = flush;
    REDIRECT_PC = redir;
    if (inject_late) begin
      gave_valid     = 1'b0;
      bus.IMEM_VALID = 1'b1;
      bus.IMEM_RDATA = 32'hDEAD_BEEF;
    end else begin
      gave_valid     = mem_busy && (mem_cnt == 0);
      bus.IMEM_VALID = gave_valid;
      bus.IMEM_RDATA = mem_addr | 32'h0000_1000;
    end
    #1;
    last_req  = bus.IMEM_REQ;
    last_addr = bus.IMEM_ADDR;
    @(posedge CLK);
    #1;
    if (gave_valid) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (last_req) begin
      mem_busy = 1'b1;
      mem_cnt  = mem_waits;
      mem_addr = last_addr;
    end
    inject_late = 1'b0;
    if (!stall && bus.D_VALID) begin
      valid_edges++;
      if (sb.size() == 0) begin
        checkOutput("sbExtra", bus.D_PC, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] exp_pc;
        exp_pc = sb.pop_front();
        checkOutput("dPc", bus.D_PC, exp_pc);
        checkOutput("dInstr", bus.D_INSTR, exp_pc | 32'h0000_1000);
        checkOutput("dPc4", bus.D_PC4, exp_pc + 32'd4);
      end
    end
    @(negedge CLK);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'd0);
  endtask

  task automatic doReset();
    RST_N          = 1'b0;
    STALL          = 1'b0;
    FLUSH          = 1'b0;
    REDIRECT_PC    = 32'd0;
    bus.IMEM_VALID = 1'b0;
    bus.IMEM_RDATA = 32'd0;
    #1;
    checkOutput("rstInstr", bus.D_INSTR, NOP);
    checkOutput("rstPc", bus.D_PC, 32'd0);
    checkOutput("rstValid", {31'd0, bus.D_VALID}, 32'd0);
    checkOutput("rstReq", {31'd0, bus.IMEM_REQ}, 32'd0);
    @(negedge CLK);
    mem_busy    = 1'b0;
    mem_cnt     = 0;
    inject_late = 1'b0;
    sb.delete();
    RST_N = 1'b1;
  endtask

  task automatic checkDrained(input string tag);
    checkOutput(tag, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST_N = 1'b0;
    STALL = 1'b0;
    FLUSH = 1'b0;
    REDIRECT_PC = 32'd0;
    bus.IMEM_VALID = 1'b0;
    bus.IMEM_RDATA = 32'd0;
    @(negedge CLK);

    // Single-cycle memory: back-to-back fetches, one instruction per cycle.
    $display("[TB] streaming with single-cycle memory");
    doReset();
    checkOutput("rstPc4", bus.D_PC4, 32'd0);
    mem_waits = 0;
    for (int i = 0; i < 9; i++) sb.push_back(32'(4 * i));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("t1Req", {31'd0, last_req}, 32'd1);
      checkOutput("t1Addr", last_addr, 32'(4 * i));
    end
    checkDrained("t1Drain");

    // Two wait states: one real instruction every third cycle.
    $display("[TB] two-wait-state memory");
    doReset();
    mem_waits = 2;
    for (int i = 0; i < 4; i++) sb.push_back(32'(4 * i));
    runCycles(3);
    valid_edges = 0;
    runCycles(12);
    checkOutput("t2ValidCount", 32'(valid_edges), 32'd4);
    checkDrained("t2Drain");

    // Stall across an arriving response: buffered, then released in order.
    $display("[TB] stall over a response");
    doReset();
    mem_waits = 0;
    sb.push_back(32'h0);  sb.push_back(32'h4);  sb.push_back(32'h8);
    sb.push_back(32'hC);  sb.push_back(32'h10);
    runCycles(3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("t3HoldPc", bus.D_PC, 32'h4);
      checkOutput("t3HoldInstr", bus.D_INSTR, 32'h1004);
      checkOutput("t3HoldValid", {31'd0, bus.D_VALID}, 32'd1);
      if (i == 0) checkOutput("t3NoReq", {31'd0, last_req}, 32'd0);
    end
    runCycles(3);
    checkDrained("t3Drain");

    // Flush while the 0x10 request is outstanding; its late response is dropped.
    $display("[TB] flush with stale outstanding request");
    doReset();
    mem_waits = 2;
    sb.push_back(32'h0);  sb.push_back(32'h4);  sb.push_back(32'h8);
    sb.push_back(32'hC);  sb.push_back(32'h200); sb.push_back(32'h204);
    runCycles(13);
    checkOutput("t4OutstandingAddr", mem_addr, 32'h10);
    applyStimulus(1'b0, 1'b1, 32'h200);
    checkOutput("t4FlushNoReq", {31'd0, last_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("t4RedirReq", {31'd0, last_req}, 32'd1);
    checkOutput("t4RedirAddr", last_addr, 32'h200);
    checkOutput("t4Bubble", {31'd0, bus.D_VALID}, 32'd0);
    runCycles(6);
    checkDrained("t4Drain");

    // Stall and flush together: flush ignored. Flush right after the stall drops: taken.
    $display("[TB] stall versus flush priority");
    doReset();
    mem_waits = 0;
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h300); sb.push_back(32'h304);
    runCycles(2);
    applyStimulus(1'b1, 1'b1, 32'h300);
    checkOutput("t5StallPc", bus.D_PC, 32'h0);
    checkOutput("t5StallNoReq", {31'd0, last_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("t5SeqAddr", last_addr, 32'h8);
    applyStimulus(1'b0, 1'b1, 32'h303);
    checkOutput("t5FlushBubble", {31'd0, bus.D_VALID}, 32'd0);
    checkOutput("t5FlushInstr", bus.D_INSTR, NOP);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("t5RedirAddr", last_addr, 32'h300);
    runCycles(2);
    checkDrained("t5Drain");

    // PC wrap-around from the top of the address space, with a misaligned redirect.
    $display("[TB] PC wrap-around");
    doReset();
    mem_waits = 0;
    sb.push_back(32'hFFFF_FFF8); sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0);         sb.push_back(32'h4);
    applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("t7AlignAddr", last_addr, 32'hFFFF_FFF8);
    runCycles(4);
    checkDrained("t7Drain");

    // Asynchronous reset while a response is pending, then a late strobe in IDLE.
    $display("[TB] reset mid-request");
    doReset();
    mem_waits = 2;
    sb.push_back(32'h0);
    runCycles(4);
    STALL = 1'b0;
    FLUSH = 1'b0;
    bus.IMEM_VALID = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("t6AsyncValid", {31'd0, bus.D_VALID}, 32'd0);
    checkOutput("t6AsyncInstr", bus.D_INSTR, NOP);
    checkOutput("t6AsyncPc", bus.D_PC, 32'd0);
    checkOutput("t6AsyncReq", {31'd0, bus.IMEM_REQ}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    mem_busy = 1'b0;
    mem_cnt  = 0;
    sb.delete();
    RST_N = 1'b1;
    sb.push_back(32'h0); sb.push_back(32'h4);
    inject_late = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("t6FirstReq", {31'd0, last_req}, 32'd1);
    checkOutput("t6FirstAddr", last_addr, 32'h0);
    checkOutput("t6LateIgnored", {31'd0, bus.D_VALID}, 32'd0);
    runCycles(6);
    checkDrained("t6Drain");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
